// File: rtl/color_bar_pkg.sv
// Shared types for the colour-bar test-pattern generator.
// Holds the display-mode enum, the RGB struct, the 3-bit palette and common widths.
// No logic state lives here; latency/backpressure are properties of the users.
package color_bar_pkg;

    localparam int PKG_COLOR_W = 8;   // channel width of rgb_t
    localparam int IDX_W       = 4;   // bar index width (up to 16 bars)
    localparam int CNT_W       = 10;  // pixel/line coordinate width

    typedef enum logic [1:0] {
        MODE_VERT   = 2'd0,
        MODE_HORZ   = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_CHECK  = 2'd3
    } mode_t;

    typedef struct packed {
        logic [PKG_COLOR_W-1:0] r;
        logic [PKG_COLOR_W-1:0] g;
        logic [PKG_COLOR_W-1:0] b;
    } rgb_t;

    // code bit0 -> red, bit1 -> green, bit2 -> blue; each channel all-ones or zero.
    function automatic rgb_t palette(input logic [2:0] code);
        rgb_t c;
        c.r = {PKG_COLOR_W{code[0]}};
        c.g = {PKG_COLOR_W{code[1]}};
        c.b = {PKG_COLOR_W{code[2]}};
        return c;
    endfunction

endpackage

// File: rtl/color_bar_gen_bar_counter.sv
// Bar/sub-position counter pair: load, advance by STEP, wrap or saturate the bar index.
// Latency: bar_o/sub_o are the combinational next-state (value in effect this cycle).
// Backpressure: none; advances whenever adv_i is high.
// Ports: clk_i, rst_i (sync active-high), load_i + load_bar_i/load_sub_i,
//        adv_i, wrap_i (1 = wrap bar at NUM_BARS-1, 0 = saturate), bar_o, sub_o.
module bar_counter
    import color_bar_pkg::*;
#(
    parameter int BAR_SIZE = 80,
    parameter int NUM_BARS = 8,
    parameter int STEP     = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [IDX_W-1:0] load_bar_i,
    input  logic [CNT_W-1:0] load_sub_i,
    input  logic             adv_i,
    input  logic             wrap_i,
    output logic [IDX_W-1:0] bar_o,
    output logic [CNT_W-1:0] sub_o
);

    localparam logic [CNT_W:0]   SIZE_L = (CNT_W+1)'(BAR_SIZE);
    localparam logic [CNT_W:0]   STEP_L = (CNT_W+1)'(STEP);
    localparam logic [IDX_W-1:0] LAST_L = IDX_W'(NUM_BARS - 1);

    logic [IDX_W-1:0] bar_q, bar_d;
    logic [CNT_W-1:0] sub_q, sub_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        bar_d = bar_q;
        sub_d = sub_q;
        sum   = {1'b0, sub_q} + STEP_L;
        if (load_i) begin
            bar_d = load_bar_i;
            sub_d = load_sub_i;
        end else if (adv_i) begin
            if (sum >= SIZE_L) begin
                // Crossed a bar boundary: carry the remainder into the next bar.
                sub_d = CNT_W'(sum - SIZE_L);
                if (bar_q == LAST_L) begin
                    bar_d = wrap_i ? '0 : LAST_L;
                end else begin
                    bar_d = bar_q + 1'b1;
                end
            end else begin
                sub_d = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bar_q <= '0;
            sub_q <= '0;
        end else begin
            bar_q <= bar_d;
            sub_q <= sub_d;
        end
    end

    assign bar_o = bar_d;
    assign sub_o = sub_d;

endmodule

// File: rtl/color_bar_gen.sv
// Multi-mode colour-bar pattern generator (vertical, horizontal, scroll, checker) for 640x480.
// Latency: 1 cycle from horizontal_num/vertical_num/video_on to red/green/blue/bar_idx/pixel_valid.
// Backpressure: none; one pixel per clk_25. Ports: load_enable = sync reset, mode_req sampled at frame start.
module color_bar_gen
    import color_bar_pkg::*;
#(
    parameter int HVID        = 640,
    parameter int VVID        = 480,
    parameter int NUM_BARS    = 8,
    parameter int COLOR_W     = 8,
    parameter int SCROLL_STEP = 2
) (
    input  logic               clk_25,
    input  logic               load_enable,
    input  logic [9:0]         horizontal_num,
    input  logic [9:0]         vertical_num,
    input  logic               video_on,
    input  logic [1:0]         mode_req,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               pixel_valid,
    output logic [3:0]         bar_idx
);

    localparam int BAR_W = HVID / NUM_BARS;
    localparam int BAR_H = VVID / NUM_BARS;
    localparam logic [CNT_W-1:0] HVID_L = CNT_W'(HVID);
    localparam logic [CNT_W-1:0] VVID_L = CNT_W'(VVID);
    localparam logic [IDX_W:0]   NB_L   = (IDX_W+1)'(NUM_BARS);

    logic frame_start, h_zero, v_zero, scroll_mode;
    assign h_zero      = (horizontal_num == '0);
    assign v_zero      = (vertical_num == '0);
    assign frame_start = h_zero && v_zero;

    mode_t mode_q, mode_d;
    assign mode_d      = frame_start ? mode_t'(mode_req) : mode_q;
    assign scroll_mode = (mode_q == MODE_SCROLL);

    // Scroll offset: advances once per frame while scrolling, wraps after NUM_BARS bars.
    logic [IDX_W-1:0] scroll_bar;
    logic [CNT_W-1:0] scroll_sub;
    bar_counter #(.BAR_SIZE(BAR_W), .NUM_BARS(NUM_BARS), .STEP(SCROLL_STEP)) u_scroll (
        .clk_i      (clk_25),
        .rst_i      (load_enable),
        .load_i     (1'b0),
        .load_bar_i ('0),
        .load_sub_i ('0),
        .adv_i      (frame_start && scroll_mode),
        .wrap_i     (1'b1),
        .bar_o      (scroll_bar),
        .sub_o      (scroll_sub)
    );

    // Horizontal position; each line starts at the scroll offset in scroll mode.
    // The sub positions of h/v are internal to the counters and not needed here.
    logic [IDX_W-1:0] h_bar, v_bar;
    logic [CNT_W-1:0] h_sub_unused, v_sub_unused;
    bar_counter #(.BAR_SIZE(BAR_W), .NUM_BARS(NUM_BARS), .STEP(1)) u_hcnt (
        .clk_i      (clk_25),
        .rst_i      (load_enable),
        .load_i     (h_zero),
        .load_bar_i (scroll_mode ? scroll_bar : '0),
        .load_sub_i (scroll_mode ? scroll_sub : '0),
        .adv_i      (!h_zero && (horizontal_num < HVID_L)),
        .wrap_i     (scroll_mode),
        .bar_o      (h_bar),
        .sub_o      (h_sub_unused)
    );

    // Vertical position only moves on the first pixel of each line.
    bar_counter #(.BAR_SIZE(BAR_H), .NUM_BARS(NUM_BARS), .STEP(1)) u_vcnt (
        .clk_i      (clk_25),
        .rst_i      (load_enable),
        .load_i     (frame_start),
        .load_bar_i ('0),
        .load_sub_i ('0),
        .adv_i      (h_zero && !v_zero && (vertical_num < VVID_L)),
        .wrap_i     (1'b0),
        .bar_o      (v_bar),
        .sub_o      (v_sub_unused)
    );

    logic [IDX_W:0]   chk_sum;
    logic [IDX_W-1:0] idx;
    rgb_t             pix;

    always_comb begin
        chk_sum = {1'b0, h_bar} + {1'b0, v_bar};
        idx     = h_bar;
        case (mode_q)
            MODE_HORZ:  idx = v_bar;
            MODE_CHECK: idx = (chk_sum >= NB_L) ? IDX_W'(chk_sum - NB_L) : chk_sum[IDX_W-1:0];
            default:    idx = h_bar;
        endcase
        pix = palette(idx[2:0]);
    end

    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        if (video_on) begin
            red_d   = {COLOR_W{|pix.r}};
            green_d = {COLOR_W{|pix.g}};
            blue_d  = {COLOR_W{|pix.b}};
            idx_d   = idx;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_25) begin
        if (load_enable) begin
            mode_q  <= MODE_VERT;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign bar_idx     = idx_q;
    assign pixel_valid = valid_q;

endmodule

// File: tb/tb_color_bar_gen.sv
// Bench for color_bar_gen: directed frames/lines with a behavioural pixel model and scoreboard.
// Latency: expectations are popped one clock after the pixel is presented.
// A second instance with NUM_BARS=3 checks bar saturation at the right edge.
module tb_color_bar_gen;

    logic       clk_25 = 1'b0;
    logic       load_enable;
    logic [9:0] horizontal_num, vertical_num;
    logic       video_on;
    logic [1:0] mode_req;

    logic [7:0] red, green, blue;
    logic       pixel_valid;
    logic [3:0] bar_idx;
    logic [7:0] red3, green3, blue3;
    logic       pixel_valid3;
    logic [3:0] bar_idx3;

    int checks   = 0;
    int failures = 0;
    int m_mode   = 0;   // model of the registered mode
    int m_off    = 0;   // model of the scroll offset in pixels
    logic [28:0] sb[$];

    always #5 clk_25 = ~clk_25;

    color_bar_gen dut (
        .clk_25(clk_25), .load_enable(load_enable),
        .horizontal_num(horizontal_num), .vertical_num(vertical_num),
        .video_on(video_on), .mode_req(mode_req),
        .red(red), .green(green), .blue(blue),
        .pixel_valid(pixel_valid), .bar_idx(bar_idx)
    );

    color_bar_gen #(.NUM_BARS(3)) dut3 (
        .clk_25(clk_25), .load_enable(load_enable),
        .horizontal_num(horizontal_num), .vertical_num(vertical_num),
        .video_on(video_on), .mode_req(mode_req),
        .red(red3), .green(green3), .blue(blue3),
        .pixel_valid(pixel_valid3), .bar_idx(bar_idx3)
    );

    // Expected {r,g,b,idx,valid} for a visible pixel with 8 bars of 80x60.
    function automatic logic [28:0] expect_px(input int h, input int v, input int mode, input int off);
        int hb, vb, idx;
        logic [3:0] i4;
        hb = h / 80;
        if (hb > 7) hb = 7;
        vb = v / 60;
        if (vb > 7) vb = 7;
        case (mode)
            0:       idx = hb;
            1:       idx = vb;
            2:       idx = ((h + off) / 80) % 8;
            default: idx = (hb + vb) % 8;
        endcase
        i4 = idx[3:0];
        return {{8{i4[0]}}, {8{i4[1]}}, {8{i4[2]}}, i4, 1'b1};
    endfunction

    task automatic chk(input string tag, input int h, input int v,
                       input logic [28:0] got, input logic [28:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s h=%0d v=%0d got=%h exp=%h", tag, h, v, got, exp);
        end
    endtask

    // Present one pixel, predict its output, compare one clock later.
    task automatic drive(input int h, input int v, input bit von, input bit rst);
        logic [28:0] e;
        horizontal_num = 10'(h);
        vertical_num   = 10'(v);
        video_on       = von;
        load_enable    = rst;
        if (rst) begin
            m_mode = 0;
            m_off  = 0;
            e      = '0;
        end else begin
            if (h == 0 && v == 0 && m_mode == 2) m_off = (m_off + 2) % 640;
            e = von ? expect_px(h, v, m_mode, m_off) : '0;
            if (h == 0 && v == 0) m_mode = int'(mode_req);
        end
        sb.push_back(e);
        @(posedge clk_25);
        #1;
        chk("px", h, v, {red, green, blue, bar_idx, pixel_valid}, sb.pop_front());
    endtask

    // Line v: pixels 0..npix-1, then one blanked out-of-range pixel if truncated.
    task automatic line(input int v, input int npix);
        for (int h = 0; h < npix; h++) drive(h, v, (h < 640) && (v < 480), 1'b0);
        if (npix < 800) drive(799, v, 1'b0, 1'b0);
    endtask

    initial begin
        mode_req = 2'd0;
        // Reset
        drive(0, 0, 1'b1, 1'b1);
        drive(0, 0, 1'b1, 1'b1);
        chk("rst3", 0, 0, {red3, green3, blue3, bar_idx3, pixel_valid3}, '0);

        // Mode 0: vertical bars on line 5, plus NUM_BARS=3 saturation
        line(0, 1);
        for (int v = 1; v < 5; v++) line(v, 1);
        for (int h = 0; h < 800; h++) begin
            drive(h, 5, h < 640, 1'b0);
            if (h == 425) chk("nb3_b1", h, 5, {red3, green3, blue3, bar_idx3, pixel_valid3},
                              {8'hFF, 8'h00, 8'h00, 4'd1, 1'b1});
            if (h == 426) chk("nb3_b2", h, 5, {red3, green3, blue3, bar_idx3, pixel_valid3},
                              {8'h00, 8'hFF, 8'h00, 4'd2, 1'b1});
            if (h == 639) chk("nb3_sat", h, 5, {red3, green3, blue3, bar_idx3, pixel_valid3},
                              {8'h00, 8'hFF, 8'h00, 4'd2, 1'b1});
        end

        // Mode 1: horizontal bars over a whole frame
        mode_req = 2'd1;
        for (int v = 0; v < 525; v++)
            line(v, (v == 30 || v == 75 || v == 450) ? 800 : 4);

        // Mode 2: scrolling, full wrap after 320 frames
        mode_req = 2'd2;
        for (int f = 1; f <= 321; f++) begin
            line(0, 1);
            if (f <= 3 || f == 321) line(1, 800);
        end

        // Mode change mid-frame is deferred to the next frame
        mode_req = 2'd0;
        line(0, 1);
        for (int v = 1; v < 200; v++) line(v, 1);
        mode_req = 2'd3;
        line(200, 800);
        for (int v = 201; v < 525; v++) line(v, 1);
        line(0, 1);
        for (int v = 1; v < 60; v++) line(v, 1);
        line(60, 800);

        // Reset mid-line clears mode and scroll offset
        mode_req = 2'd2;
        line(0, 1);
        line(0, 1);
        line(0, 1);
        for (int h = 0; h < 100; h++) drive(h, 1, 1'b1, 1'b0);
        drive(100, 1, 1'b1, 1'b1);
        drive(799, 1, 1'b0, 1'b0);
        line(0, 1);
        line(1, 800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
